// File: rtl/chip_uart_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
package chip_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BAUD_DIV_DEFAULT = 434;
  localparam int unsigned CNT_W            = 16;
  localparam logic        UART_IDLE        = 1'b1;

endpackage

// File: rtl/chip_uart_baud.sv
// Bit-period timer: counts 0..BAUD_DIV-1, flags the last cycle of each bit.
module chip_uart_baud
  import chip_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic restart,
  output logic bit_tick,
  output logic bit_tick_nxt_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Look-ahead lets the parent register outputs aligned to the tick cycle.
  assign bit_tick_nxt_c = (cnt_d == LAST);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_tick_q <= bit_tick_nxt_c;
    end
  end

  assign bit_tick = bit_tick_q;

endmodule

// File: rtl/chip_uart_tx.sv
// 16-bit word UART transmitter: two 8N1 bytes per word (high byte first),
// one-word holding register and saturating drop counter.
module chip_uart_tx
  import chip_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] tx_data,
  input  logic        tx_vld,
  output logic        tx_done,
  output logic        tx_busy,
  output logic [7:0]  ovf_cnt,
  output logic        uart_tx
);

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BITCNT_W  = 3;
  localparam int unsigned OVF_W     = 8;
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e         state_q, state_d;
  logic                byte_sel_q, byte_sel_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic [BYTE_W-1:0]   sh_q, sh_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;
  logic                uart_tx_q, uart_tx_d;
  logic                tx_done_q, tx_done_d;
  logic                tx_busy_q, tx_busy_d;

  logic                bit_tick, bit_tick_nxt_c;
  logic                word_end, direct_start, pop_hold, load_word;
  logic [WORD_W-1:0]   next_word;

  chip_uart_baud #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .restart        (state_q == IDLE),
    .bit_tick       (bit_tick),
    .bit_tick_nxt_c (bit_tick_nxt_c)
  );

  always_comb begin
    state_d     = state_q;
    byte_sel_d  = byte_sel_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    sh_d        = sh_q;
    lo_d        = lo_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;

    word_end     = (state_q == STOP) && bit_tick && (stop_cnt_q == STOP_LAST) && byte_sel_q;
    direct_start = tx_vld && !hold_full_q && ((state_q == IDLE) || word_end);
    pop_hold     = word_end && hold_full_q;
    load_word    = pop_hold || direct_start;
    next_word    = pop_hold ? hold_q : tx_data;

    // Holding register frees in the same cycle it is popped, so a coincident offer is kept.
    if (pop_hold) begin
      hold_full_d = 1'b0;
    end
    if (tx_vld && !direct_start) begin
      if (!hold_full_q || pop_hold) begin
        hold_d      = tx_data;
        hold_full_d = 1'b1;
      end else if (ovf_q != {OVF_W{1'b1}}) begin
        ovf_d = ovf_q + OVF_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (load_word) begin
          state_d    = START;
          byte_sel_d = 1'b0;
          sh_d       = next_word[15:8];
          lo_d       = next_word[7:0];
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BITCNT_W'(BYTE_W - 1)) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            sh_d      = sh_q >> 1;
            bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = 1'b1;
          end else if (!byte_sel_q) begin
            state_d    = START;
            byte_sel_d = 1'b1;
            sh_d       = lo_q;
          end else if (load_word) begin
            state_d    = START;
            byte_sel_d = 1'b0;
            sh_d       = next_word[15:8];
            lo_d       = next_word[7:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so the registered copies line up.
    case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = sh_d[0];
      default: uart_tx_d = UART_IDLE;
    endcase
    tx_busy_d = (state_d != IDLE) || hold_full_d;
    tx_done_d = (state_d == STOP) && byte_sel_d && (stop_cnt_d == STOP_LAST) && bit_tick_nxt_c;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_sel_q  <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      sh_q        <= '0;
      lo_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= '0;
      uart_tx_q   <= UART_IDLE;
      tx_done_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_sel_q  <= byte_sel_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      sh_q        <= sh_d;
      lo_q        <= lo_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      uart_tx_q   <= uart_tx_d;
      tx_done_q   <= tx_done_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign tx_done = tx_done_q;
  assign tx_busy = tx_busy_q;
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_chip_uart_tx.sv
// Directed bench for chip_uart_tx at BAUD_DIV=4, STOP_BITS=1.
module tb_chip_uart_tx;

  localparam int BAUD     = 4;
  localparam int WORD_CYC = 20 * BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_vld = 1'b0;
  logic        tx_done;
  logic        tx_busy;
  logic [7:0]  ovf_cnt;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  chip_uart_tx #(.BAUD_DIV(BAUD), .STOP_BITS(1)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_done (tx_done),
    .tx_busy (tx_busy),
    .ovf_cnt (ovf_cnt),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line level for bit b (0..19) of a word: start, 8 data LSB first, stop; high byte first.
  function automatic logic exp_bit(input logic [15:0] w, input int b);
    logic [7:0] by;
    int         k;
    by = (b < 10) ? w[15:8] : w[7:0];
    k  = b % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return by[k-1];
  endfunction

  // Offers a word from idle; returns in the first cycle of its start bit.
  task automatic send(input logic [15:0] d);
    tx_vld  = 1'b1;
    tx_data = d;
    cyc();
    tx_vld  = 1'b0;
    tx_data = ~d;
  endtask

  // Checks every cycle of one word on the line; optionally offers words at given cycle indices.
  task automatic check_word(input logic [15:0] w, input int a0, input logic [15:0] d0,
                            input int a1, input logic [15:0] d1);
    int idx;
    for (int b = 0; b < 20; b++) begin
      for (int c = 0; c < BAUD; c++) begin
        idx = b * BAUD + c;
        check_bit($sformatf("w%04h[%0d] uart_tx", w, idx), uart_tx, exp_bit(w, b));
        check_bit($sformatf("w%04h[%0d] tx_done", w, idx), tx_done, idx == WORD_CYC - 1);
        check_bit($sformatf("w%04h[%0d] tx_busy", w, idx), tx_busy, 1'b1);
        if (idx == a0) begin
          tx_vld = 1'b1; tx_data = d0;
        end else if (idx == a1) begin
          tx_vld = 1'b1; tx_data = d1;
        end
        cyc();
        if (tx_vld) tx_data = ~tx_data;
        tx_vld = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_bit({tag, " uart_tx"}, uart_tx, 1'b1);
      check_bit({tag, " tx_busy"}, tx_busy, 1'b0);
      check_bit({tag, " tx_done"}, tx_done, 1'b0);
      cyc();
    end
  endtask

  initial begin
    // Reset values appear before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_bit("rst uart_tx", uart_tx, 1'b1);
    check_bit("rst tx_busy", tx_busy, 1'b0);
    check_bit("rst tx_done", tx_done, 1'b0);
    check_val("rst ovf_cnt", ovf_cnt, 8'd0);
    repeat (3) cyc();
    rst = 1'b0;
    check_idle("post-rst", 4);

    // Single word
    send(16'hA55A);
    check_word(16'hA55A, -1, 16'h0, -1, 16'h0);
    check_idle("single", 3);

    // Back-to-back: second word offered two cycles after the first
    send(16'h1234);
    check_word(16'h1234, 1, 16'hABCD, -1, 16'h0);
    check_word(16'hABCD, -1, 16'h0, -1, 16'h0);
    check_idle("b2b", 3);
    check_val("b2b ovf_cnt", ovf_cnt, 8'd0);

    // Overflow: third word within 5 cycles is dropped
    send(16'h0F0F);
    check_word(16'h0F0F, 1, 16'h3C3C, 3, 16'h7777);
    check_word(16'h3C3C, -1, 16'h0, -1, 16'h0);
    check_idle("ovf", 3);
    check_val("ovf one drop", ovf_cnt, 8'd1);

    // Coincidence in the tx_done cycle, then a fresh word on an empty holding register
    send(16'h1111);
    check_word(16'h1111, 2, 16'h2222, WORD_CYC - 1, 16'h3333);
    check_word(16'h2222, -1, 16'h0, -1, 16'h0);
    check_word(16'h3333, WORD_CYC - 1, 16'h4444, -1, 16'h0);
    check_word(16'h4444, -1, 16'h0, -1, 16'h0);
    check_idle("coinc", 3);
    check_val("coinc ovf_cnt", ovf_cnt, 8'd1);

    // Saturation: continuous offers for 300 cycles
    tx_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tx_data = 16'($urandom);
      cyc();
    end
    tx_vld = 1'b0;
    check_val("sat ovf_cnt", ovf_cnt, 8'd255);
    for (int i = 0; i < 400 && tx_busy; i++) cyc();
    check_bit("sat drain tx_busy", tx_busy, 1'b0);
    check_val("sat ovf_cnt held", ovf_cnt, 8'd255);
    check_idle("sat", 2);

    // Reset 30 cycles into a word
    send(16'hFFFF);
    for (int i = 0; i < 30; i++) begin
      check_bit("pre-rst tx_done", tx_done, 1'b0);
      cyc();
    end
    rst = 1'b1;
    #1;
    check_bit("midrst uart_tx", uart_tx, 1'b1);
    check_bit("midrst tx_busy", tx_busy, 1'b0);
    check_bit("midrst tx_done", tx_done, 1'b0);
    check_val("midrst ovf_cnt", ovf_cnt, 8'd0);
    cyc();
    cyc();
    rst = 1'b0;
    check_idle("after midrst", 100);
    send(16'h0001);
    check_word(16'h0001, -1, 16'h0, -1, 16'h0);
    check_idle("final", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
